// File: rtl/toe_pkg.sv
// Shared definitions for the TCP offload connection table.
// Holds table geometry, tuple field layout, response codes and FSM encoding.
// Pure declarations; no logic.
package toe_pkg;

  localparam int DEPTH   = 16;
  localparam int ID_W    = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int TUPLE_W = 36;

  // Tuple layout, MSB first: {dst_port, src_port, dst_ip, src_ip, dst_mac, src_mac}
  localparam int SRC_MAC_LSB  = 0;
  localparam int SRC_MAC_W    = 6;
  localparam int DST_MAC_LSB  = 6;
  localparam int DST_MAC_W    = 6;
  localparam int SRC_IP_LSB   = 12;
  localparam int SRC_IP_W     = 7;
  localparam int DST_IP_LSB   = 19;
  localparam int DST_IP_W     = 7;
  localparam int SRC_PORT_LSB = 26;
  localparam int SRC_PORT_W   = 5;
  localparam int DST_PORT_LSB = 31;
  localparam int DST_PORT_W   = 5;

  typedef enum logic [1:0] {
    ERR_OK   = 2'b00,
    ERR_DUP  = 2'b01,
    ERR_FULL = 2'b10,
    ERR_BAD  = 2'b11
  } resp_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_KILL = 2'b10,
    ST_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/toe_conn_table_if.sv
// Request/response bus of the connection table.
// Request side is valid/ready; response side is a one-cycle pulse.
// master drives requests, slave (the table) answers.
interface toe_conn_table_if #(
  parameter int ID_W    = toe_pkg::ID_W,
  parameter int TUPLE_W = toe_pkg::TUPLE_W,
  parameter int CNT_W   = toe_pkg::CNT_W
);
  import toe_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_new;
  logic               req_kill;
  logic [ID_W-1:0]    req_kill_id;
  logic [TUPLE_W-1:0] req_tuple;
  logic               resp_valid;
  logic [ID_W-1:0]    resp_id;
  logic [1:0]         resp_err;
  logic               busy;
  logic [CNT_W-1:0]   active_count;

  modport master (
    output req_valid, req_new, req_kill, req_kill_id, req_tuple,
    input  req_ready, resp_valid, resp_id, resp_err, busy, active_count
  );

  modport slave (
    input  req_valid, req_new, req_kill, req_kill_id, req_tuple,
    output req_ready, resp_valid, resp_id, resp_err, busy, active_count
  );

endinterface

// File: rtl/toe_tuple_ram.sv
// Tuple storage: single address port, synchronous write, combinational read.
// Latency: read 0 cycles, write visible after the next rising edge.
// No backpressure; contents are not reset.
module toe_tuple_ram #(
  parameter int DEPTH   = toe_pkg::DEPTH,
  parameter int TUPLE_W = toe_pkg::TUPLE_W,
  parameter int ID_W    = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [ID_W-1:0]    i_addr,
  input  logic [TUPLE_W-1:0] i_wdat,
  output logic [TUPLE_W-1:0] o_rdat
);

  logic [TUPLE_W-1:0] r_mem [DEPTH];

  // Write port: one tuple per cycle at the shared address.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdat;
  end

  assign o_rdat = r_mem[i_addr];

endmodule

// File: rtl/toe_conn_table.sv
// Connection table: open (linear scan for duplicate/free slot) or close entries.
// Latency: new -> resp DEPTH+1 cycles after accept, kill -> 2, no opcode -> 1.
// One request in flight; req_ready low outside IDLE, requests then are ignored.
module toe_conn_table
  import toe_pkg::*;
#(
  parameter int DEPTH   = toe_pkg::DEPTH,
  parameter int TUPLE_W = toe_pkg::TUPLE_W
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  toe_conn_table_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  state_e             r_state;
  logic [DEPTH-1:0]   r_valid;
  logic [IW-1:0]      r_idx;
  logic [TUPLE_W-1:0] r_tuple;
  logic [IW-1:0]      r_kill_id;
  logic               r_match_found;
  logic [IW-1:0]      r_match_idx;
  logic               r_free_found;
  logic [IW-1:0]      r_free_idx;
  logic               r_alloc;
  logic               r_ready;
  logic               r_resp_valid;
  logic [IW-1:0]      r_resp_id;
  resp_err_e          r_resp_err;
  logic [CW-1:0]      r_count;

  logic [TUPLE_W-1:0] w_ram_rdat;
  logic [IW-1:0]      w_ram_addr;
  logic               w_ram_we;
  logic               w_hit;
  logic               w_free;
  logic               w_match_any;
  logic [IW-1:0]      w_match_idx;
  logic               w_free_any;
  logic [IW-1:0]      w_free_idx;

  // The RAM has one port: it is read by the scan, and the allocated tuple is
  // written during RESP, after the scan has finished with the port.
  assign w_ram_we   = (r_state == ST_RESP) && r_alloc;
  assign w_ram_addr = (r_state == ST_RESP) ? r_resp_id : r_idx;

  toe_tuple_ram #(
    .DEPTH   (DEPTH),
    .TUPLE_W (TUPLE_W),
    .ID_W    (IW)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_wdat (r_tuple),
    .o_rdat (w_ram_rdat)
  );

  // Current scan entry, merged with what earlier entries already recorded so
  // the final decision can be taken on the last scan cycle itself.
  assign w_hit       = r_valid[r_idx] && (w_ram_rdat == r_tuple);
  assign w_free      = !r_valid[r_idx];
  assign w_match_any = r_match_found || w_hit;
  assign w_match_idx = r_match_found ? r_match_idx : r_idx;
  assign w_free_any  = r_free_found || w_free;
  assign w_free_idx  = r_free_found ? r_free_idx : r_idx;

  // Control FSM with valid bits, occupancy counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_valid       <= '0;
      r_idx         <= '0;
      r_tuple       <= '0;
      r_kill_id     <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
      r_alloc       <= 1'b0;
      r_ready       <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= '0;
      r_resp_err    <= ERR_OK;
      r_count       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_resp_valid <= 1'b0;
          r_alloc      <= 1'b0;
          if (bus.req_valid) begin
            r_tuple   <= bus.req_tuple;
            r_kill_id <= bus.req_kill_id;
            r_ready   <= 1'b0;
            if (bus.req_kill) begin
              r_state <= ST_KILL;
            end else if (bus.req_new) begin
              r_state       <= ST_SCAN;
              r_idx         <= '0;
              r_match_found <= 1'b0;
              r_free_found  <= 1'b0;
            end else begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_id    <= '0;
              r_resp_err   <= ERR_BAD;
            end
          end
        end

        ST_SCAN: begin
          if (w_hit && !r_match_found) begin
            r_match_found <= 1'b1;
            r_match_idx   <= r_idx;
          end
          if (w_free && !r_free_found) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
          end
          if (r_idx == LAST_IDX) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            if (w_match_any) begin
              r_resp_id  <= w_match_idx;
              r_resp_err <= ERR_DUP;
            end else if (!w_free_any) begin
              r_resp_id  <= '0;
              r_resp_err <= ERR_FULL;
            end else begin
              r_valid[w_free_idx] <= 1'b1;
              r_alloc             <= 1'b1;
              r_resp_id           <= w_free_idx;
              r_resp_err          <= ERR_OK;
              if (r_count != CW'(DEPTH)) r_count <= r_count + CW'(1);
            end
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end

        ST_KILL: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_id    <= r_kill_id;
          if (r_valid[r_kill_id]) begin
            r_valid[r_kill_id] <= 1'b0;
            r_resp_err         <= ERR_OK;
            if (r_count != '0) r_count <= r_count - CW'(1);
          end else begin
            r_resp_err <= ERR_BAD;
          end
        end

        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_alloc      <= 1'b0;
          r_ready      <= 1'b1;
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready    = r_ready;
  assign bus.busy         = !r_ready;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_id      = r_resp_id;
  assign bus.resp_err     = r_resp_err;
  assign bus.active_count = r_count;

endmodule
